// File: rtl/accel_pkg.sv
// Shared definitions for the LeNet-5 tile array: command encodings, layer geometry
// and scheduler state types used by both the layer scheduler and the tile FSM.
package accel_pkg;

    typedef enum logic [1:0] {
        CAL_IDLE = 2'b00,
        CAL_FULL = 2'b01,
        CAL_PART = 2'b10
    } cal_e;

    typedef enum logic [2:0] {
        LAYER_NONE = 3'b000,
        LAYER_C1   = 3'b001,
        LAYER_S2   = 3'b010,
        LAYER_C3   = 3'b011,
        LAYER_S4   = 3'b100,
        LAYER_C5   = 3'b101
    } layer_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } sched_state_e;

    // Conv layers produce one PE-row-wide chunk per tile, pooling layers four columns.
    localparam int unsigned CONV_CHUNK = 5;
    localparam int unsigned POOL_CHUNK = 4;

    localparam int unsigned C1_MAPS = 6;
    localparam int unsigned C1_W    = 28;
    localparam int unsigned C1_CHUNK = CONV_CHUNK;
    localparam int unsigned S2_MAPS = 6;
    localparam int unsigned S2_W    = 14;
    localparam int unsigned S2_CHUNK = POOL_CHUNK;
    localparam int unsigned C3_MAPS = 16;
    localparam int unsigned C3_W    = 10;
    localparam int unsigned C3_CHUNK = CONV_CHUNK;
    localparam int unsigned S4_MAPS = 16;
    localparam int unsigned S4_W    = 5;
    localparam int unsigned S4_CHUNK = POOL_CHUNK;
    localparam int unsigned C5_MAPS = 120;
    localparam int unsigned C5_W    = 1;
    localparam int unsigned C5_CHUNK = CONV_CHUNK;

    typedef struct packed {
        logic [6:0] maps;
        logic [4:0] width;
        logic [2:0] chunk;
    } geom_t;

    typedef struct packed {
        layer_e     layer;
        logic [6:0] map;
        logic [4:0] row;
        logic [4:0] col;
    } tile_pos_t;

    typedef struct packed {
        logic       en_tf;
        cal_e       cal_state;
        layer_e     layer_state;
        logic [6:0] map_idx;
        logic [4:0] row_idx;
        logic [4:0] col_base;
        logic [2:0] valid_cols;
        logic       busy;
        logic       done;
    } sched_out_t;

    function automatic logic layer_last(input layer_e layer);
        return layer == LAYER_C5;
    endfunction

    function automatic layer_e layer_next(input layer_e layer);
        case (layer)
            LAYER_C1: return LAYER_S2;
            LAYER_S2: return LAYER_C3;
            LAYER_C3: return LAYER_S4;
            LAYER_S4: return LAYER_C5;
            default:  return LAYER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/layer_scheduler_if.sv
// Host/datapath handshake and tile-command bundle of the layer scheduler.
// master = host/datapath side, slave = scheduler side.
interface layer_scheduler_if;

    logic       start;
    logic       abort;
    logic       tile_done;
    logic       en_tf;
    logic [1:0] cal_state;
    logic [2:0] layer_state;
    logic [6:0] map_idx;
    logic [4:0] row_idx;
    logic [4:0] col_base;
    logic [2:0] valid_cols;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, tile_done,
        input  en_tf, cal_state, layer_state, map_idx, row_idx, col_base,
               valid_cols, busy, done
    );

    modport slave (
        input  start, abort, tile_done,
        output en_tf, cal_state, layer_state, map_idx, row_idx, col_base,
               valid_cols, busy, done
    );

endinterface

// File: rtl/layer_geom_lut.sv
// Combinational layer -> {output maps, map width/height, chunk width} lookup.
module layer_geom_lut
    import accel_pkg::*;
(
    input  layer_e layer,
    output geom_t  geom
);

    always_comb begin
        geom = '0;
        case (layer)
            LAYER_C1: geom = '{maps: 7'(C1_MAPS), width: 5'(C1_W), chunk: 3'(C1_CHUNK)};
            LAYER_S2: geom = '{maps: 7'(S2_MAPS), width: 5'(S2_W), chunk: 3'(S2_CHUNK)};
            LAYER_C3: geom = '{maps: 7'(C3_MAPS), width: 5'(C3_W), chunk: 3'(C3_CHUNK)};
            LAYER_S4: geom = '{maps: 7'(S4_MAPS), width: 5'(S4_W), chunk: 3'(S4_CHUNK)};
            LAYER_C5: geom = '{maps: 7'(C5_MAPS), width: 5'(C5_W), chunk: 3'(C5_CHUNK)};
            default:  geom = '0;
        endcase
    end

endmodule

// File: rtl/layer_scheduler.sv
// LeNet-5 layer sequencer: walks C1..C5 over maps, rows and column chunks,
// issuing one tile command at a time and waiting for tile_done.
module layer_scheduler
    import accel_pkg::*;
#(
    parameter int unsigned ROWS = 5,
    parameter int unsigned COLS = 5
) (
    input logic              clk,
    input logic              rst_n,
    layer_scheduler_if.slave bus
);

    if (ROWS != CONV_CHUNK) begin : g_rows_check
        $error("layer_scheduler: ROWS must match the conv chunk width");
    end
    if (COLS != 5) begin : g_cols_check
        $error("layer_scheduler: COLS must be 5");
    end

    sched_state_e state_q;
    logic         pend_q;
    logic         last_q;
    tile_pos_t    pos_q;
    sched_out_t   out_q;

    geom_t        geom;
    logic [5:0]   col_end;
    logic         col_wrap;
    logic         row_wrap;
    logic         map_wrap;
    tile_pos_t    pos_nxt;
    logic         pos_last;
    sched_out_t   issue_out;

    layer_geom_lut u_geom (
        .layer (pos_q.layer),
        .geom  (geom)
    );

    always_comb begin
        col_end  = {1'b0, pos_q.col} + {3'b000, geom.chunk};
        col_wrap = col_end >= {1'b0, geom.width};
        row_wrap = pos_q.row == (geom.width - 5'd1);
        map_wrap = pos_q.map == (geom.maps - 7'd1);

        pos_nxt  = pos_q;
        pos_last = 1'b0;
        if (col_wrap) begin
            pos_nxt.col = '0;
            if (row_wrap) begin
                pos_nxt.row = '0;
                if (map_wrap) begin
                    pos_nxt.map   = '0;
                    pos_nxt.layer = layer_next(pos_q.layer);
                    pos_last      = layer_last(pos_q.layer);
                end else begin
                    pos_nxt.map = pos_q.map + 7'd1;
                end
            end else begin
                pos_nxt.row = pos_q.row + 5'd1;
            end
        end else begin
            pos_nxt.col = col_end[4:0];
        end

        issue_out             = '0;
        issue_out.en_tf       = 1'b1;
        issue_out.busy        = 1'b1;
        issue_out.layer_state = pos_q.layer;
        issue_out.map_idx     = pos_q.map;
        issue_out.row_idx     = pos_q.row;
        issue_out.col_base    = pos_q.col;
        if (col_end <= {1'b0, geom.width}) begin
            issue_out.cal_state  = CAL_FULL;
            issue_out.valid_cols = geom.chunk;
        end else begin
            issue_out.cal_state  = CAL_PART;
            issue_out.valid_cols = 3'(geom.width - pos_q.col);
        end
    end

    // Start is taken into pend_q first so the first command appears one cycle
    // after the accepting edge; pos_q is advanced on leaving WAIT so ADVANCE
    // can build the next command from settled counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            pos_q   <= '0;
            out_q   <= '0;
        end else if (bus.abort && (state_q != S_IDLE || pend_q)) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            pos_q   <= '0;
            out_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        pend_q  <= 1'b0;
                        state_q <= S_ISSUE;
                        out_q   <= issue_out;
                    end else if (bus.start) begin
                        pend_q <= 1'b1;
                        pos_q  <= '{layer: LAYER_C1, map: '0, row: '0, col: '0};
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.tile_done) begin
                        state_q         <= S_ADVANCE;
                        out_q.en_tf     <= 1'b0;
                        out_q.cal_state <= CAL_IDLE;
                        pos_q           <= pos_nxt;
                        last_q          <= pos_last;
                    end
                end
                S_ADVANCE: begin
                    if (last_q) begin
                        state_q    <= S_DONE;
                        last_q     <= 1'b0;
                        pos_q      <= '0;
                        out_q      <= '0;
                        out_q.done <= 1'b1;
                    end else begin
                        state_q <= S_ISSUE;
                        out_q   <= issue_out;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    out_q   <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    out_q   <= '0;
                end
            endcase
        end
    end

    assign bus.en_tf       = out_q.en_tf;
    assign bus.cal_state   = out_q.cal_state;
    assign bus.layer_state = out_q.layer_state;
    assign bus.map_idx     = out_q.map_idx;
    assign bus.row_idx     = out_q.row_idx;
    assign bus.col_base    = out_q.col_base;
    assign bus.valid_cols  = out_q.valid_cols;
    assign bus.busy        = out_q.busy;
    assign bus.done        = out_q.done;

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler against a nested-loop model of the pass.
`timescale 1ns/1ps
module tb_layer_scheduler;

    typedef struct packed {
        logic [2:0] layer;
        logic [6:0] map;
        logic [4:0] row;
        logic [4:0] col;
        logic [1:0] cal;
        logic [2:0] vcols;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    layer_scheduler_if bus ();

    layer_scheduler #(.ROWS(5), .COLS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cmd_t model_q[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic cmd_t cur_cmd();
        cmd_t c;
        c.layer = bus.layer_state;
        c.map   = bus.map_idx;
        c.row   = bus.row_idx;
        c.col   = bus.col_base;
        c.cal   = bus.cal_state;
        c.vcols = bus.valid_cols;
        return c;
    endfunction

    function automatic logic [27:0] all_outs();
        return {bus.en_tf, bus.cal_state, bus.layer_state, bus.map_idx, bus.row_idx,
                bus.col_base, bus.valid_cols, bus.busy, bus.done};
    endfunction

    function automatic string cmd_str(input cmd_t c);
        return $sformatf("L%0d m%0d r%0d c%0d cal%0d v%0d",
                         c.layer, c.map, c.row, c.col, c.cal, c.vcols);
    endfunction

    // Expected command stream, straight from the layer geometry table.
    task automatic build_model();
        int maps[5]  = '{6, 6, 16, 16, 120};
        int width[5] = '{28, 14, 10, 5, 1};
        int chunk[5] = '{5, 4, 5, 4, 5};
        cmd_t e;
        for (int l = 0; l < 5; l++)
            for (int m = 0; m < maps[l]; m++)
                for (int r = 0; r < width[l]; r++)
                    for (int c = 0; c < width[l]; c += chunk[l]) begin
                        e.layer = 3'(l + 1);
                        e.map   = 7'(m);
                        e.row   = 5'(r);
                        e.col   = 5'(c);
                        if (c + chunk[l] <= width[l]) begin
                            e.cal   = 2'b01;
                            e.vcols = 3'(chunk[l]);
                        end else begin
                            e.cal   = 2'b10;
                            e.vcols = 3'(width[l] - c);
                        end
                        model_q.push_back(e);
                    end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic abort_pass();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.tile_done = 1'b0;
        repeat (3) tick();
        checks++;
        if (all_outs() !== 28'd0) begin
            fails++;
            $display("FAIL reset_hold outputs=%h required 0", all_outs());
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (all_outs() !== 28'd0) begin
                fails++;
                $display("FAIL idle_no_start cycle %0d outputs=%h required 0", i, all_outs());
            end
        end
    endtask

    task automatic test_first_tiles();
        logic pe = 1'b0;
        int   n  = 0;
        bus.tile_done = 1'b1;
        start_pass();
        for (int cyc = 0; cyc < 100 && n < 7; cyc++) begin
            tick();
            if (bus.en_tf && !pe) begin
                checks++;
                if (cur_cmd() !== model_q[n]) begin
                    fails++;
                    $display("FAIL first_tiles[%0d] got %s required %s", n,
                             cmd_str(cur_cmd()), cmd_str(model_q[n]));
                end
                n++;
            end
            pe = bus.en_tf;
        end
        checks++;
        if (n != 7) begin
            fails++;
            $display("FAIL first_tiles_count got %0d required 7", n);
        end
        bus.tile_done = 1'b0;
        abort_pass();
    endtask

    task automatic test_full_pass();
        logic pe       = 1'b0;
        int   issues   = 0;
        int   done_cyc = 0;
        cmd_t last     = '0;
        cmd_t last_exp;
        last_exp = '{layer: 3'd5, map: 7'd119, row: 5'd0, col: 5'd0, cal: 2'b10, vcols: 3'd1};
        bus.tile_done = 1'b1;
        start_pass();
        for (int cyc = 1; cyc <= 7000 && done_cyc == 0; cyc++) begin
            tick();
            if (bus.en_tf && !pe) begin
                checks++;
                if (issues >= model_q.size()) begin
                    fails++;
                    $display("FAIL full_pass_extra got %s required no command", cmd_str(cur_cmd()));
                end else if (cur_cmd() !== model_q[issues]) begin
                    fails++;
                    $display("FAIL full_pass[%0d] got %s required %s", issues,
                             cmd_str(cur_cmd()), cmd_str(model_q[issues]));
                end
                last = cur_cmd();
                issues++;
            end
            if (bus.busy && !bus.en_tf) begin
                checks++;
                if (bus.cal_state !== 2'b00) begin
                    fails++;
                    $display("FAIL advance_cal got %b required 00", bus.cal_state);
                end
            end
            if (bus.done) begin
                done_cyc = cyc;
                checks++;
                if ({bus.busy, bus.en_tf} !== 2'b00) begin
                    fails++;
                    $display("FAIL done_busy got busy=%b en_tf=%b required 0 0", bus.busy, bus.en_tf);
                end
            end
            pe = bus.en_tf;
        end
        checks++;
        if (issues != 1944) begin
            fails++;
            $display("FAIL issue_count got %0d required 1944", issues);
        end
        checks++;
        if (done_cyc != 5833) begin
            fails++;
            $display("FAIL done_latency got %0d required 5833", done_cyc);
        end
        checks++;
        if (last !== last_exp) begin
            fails++;
            $display("FAIL last_command got %s required %s", cmd_str(last), cmd_str(last_exp));
        end
        bus.tile_done = 1'b0;
        tick();
        checks++;
        if (all_outs() !== 28'd0) begin
            fails++;
            $display("FAIL after_done outputs=%h required 0", all_outs());
        end
    endtask

    task automatic test_layer_boundary();
        logic pe    = 1'b0;
        logic found = 1'b0;
        logic got   = 1'b0;
        cmd_t target;
        cmd_t next_exp;
        target   = '{layer: 3'd3, map: 7'd15, row: 5'd9, col: 5'd5, cal: 2'b01, vcols: 3'd5};
        next_exp = '{layer: 3'd4, map: 7'd0, row: 5'd0, col: 5'd0, cal: 2'b01, vcols: 3'd4};
        bus.tile_done = 1'b1;
        start_pass();
        for (int cyc = 0; cyc < 6000 && !found; cyc++) begin
            tick();
            if (bus.en_tf && !pe && cur_cmd() === target) begin
                found = 1'b1;
                bus.tile_done = 1'b0;
            end
            pe = bus.en_tf;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL boundary_reach got no C3 m15 r9 c5 command required one");
        end
        repeat (2) tick();
        checks++;
        if ({bus.en_tf, cur_cmd()} !== {1'b1, target}) begin
            fails++;
            $display("FAIL boundary_hold got en=%b %s required en=1 %s", bus.en_tf,
                     cmd_str(cur_cmd()), cmd_str(target));
        end
        bus.tile_done = 1'b1;
        tick();
        bus.tile_done = 1'b0;
        pe = bus.en_tf;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            tick();
            if (bus.en_tf && !pe) got = 1'b1;
            pe = bus.en_tf;
        end
        checks++;
        if (!got || cur_cmd() !== next_exp) begin
            fails++;
            $display("FAIL boundary_next got %s (seen=%b) required %s", cmd_str(cur_cmd()), got,
                     cmd_str(next_exp));
        end
        abort_pass();
    endtask

    task automatic test_abort();
        logic pe    = 1'b0;
        logic found = 1'b0;
        logic got   = 1'b0;
        int   k     = $urandom_range(0, 335);
        int   seen  = 0;
        bus.tile_done = 1'b1;
        start_pass();
        for (int cyc = 0; cyc < 6000 && !found; cyc++) begin
            tick();
            if (bus.en_tf && !pe && bus.layer_state == 3'b010) begin
                if (seen == k) begin
                    found = 1'b1;
                    bus.tile_done = 1'b0;
                end
                seen++;
            end
            pe = bus.en_tf;
        end
        tick();
        checks++;
        if (!found || bus.en_tf !== 1'b1) begin
            fails++;
            $display("FAIL abort_setup got found=%b en_tf=%b required 1 1", found, bus.en_tf);
        end
        // abort must win over a simultaneous tile_done and start
        bus.abort     = 1'b1;
        bus.tile_done = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.tile_done = 1'b0;
        bus.start     = 1'b0;
        checks++;
        if (all_outs() !== 28'd0) begin
            fails++;
            $display("FAIL abort_outputs outputs=%h required 0", all_outs());
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (all_outs() !== 28'd0) begin
                fails++;
                $display("FAIL abort_idle cycle %0d outputs=%h required 0", i, all_outs());
            end
        end
        start_pass();
        pe = bus.en_tf;
        for (int cyc = 0; cyc < 5 && !got; cyc++) begin
            tick();
            if (bus.en_tf && !pe) got = 1'b1;
            pe = bus.en_tf;
        end
        checks++;
        if (!got || cur_cmd() !== model_q[0]) begin
            fails++;
            $display("FAIL abort_restart got %s (seen=%b) required %s", cmd_str(cur_cmd()), got,
                     cmd_str(model_q[0]));
        end
        abort_pass();
    endtask

    task automatic test_ignored_inputs();
        logic pe  = 1'b0;
        logic got = 1'b0;
        bus.tile_done = 1'b0;
        start_pass();
        tick();
        checks++;
        if ({bus.en_tf, cur_cmd()} !== {1'b1, model_q[0]}) begin
            fails++;
            $display("FAIL ignored_first got en=%b %s required en=1 %s", bus.en_tf,
                     cmd_str(cur_cmd()), cmd_str(model_q[0]));
        end
        bus.tile_done = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.tile_done = 1'b0;
        bus.start     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.en_tf, bus.busy, cur_cmd()} !== {2'b11, model_q[0]}) begin
                fails++;
                $display("FAIL ignored_issue_hold cycle %0d got en=%b busy=%b %s required 1 1 %s", i,
                         bus.en_tf, bus.busy, cmd_str(cur_cmd()), cmd_str(model_q[0]));
            end
            tick();
        end
        bus.tile_done = 1'b1;
        tick();
        bus.tile_done = 1'b0;
        pe = bus.en_tf;
        for (int cyc = 0; cyc < 5 && !got; cyc++) begin
            tick();
            if (bus.en_tf && !pe) got = 1'b1;
            pe = bus.en_tf;
        end
        tick();
        bus.start = 1'b1;
        repeat (2) tick();
        bus.start     = 1'b0;
        bus.tile_done = 1'b1;
        tick();
        bus.tile_done = 1'b0;
        got = 1'b0;
        pe  = bus.en_tf;
        for (int cyc = 0; cyc < 5 && !got; cyc++) begin
            tick();
            if (bus.en_tf && !pe) got = 1'b1;
            pe = bus.en_tf;
        end
        checks++;
        if (!got || cur_cmd() !== model_q[2]) begin
            fails++;
            $display("FAIL ignored_start_wait got %s (seen=%b) required %s", cmd_str(cur_cmd()), got,
                     cmd_str(model_q[2]));
        end
        abort_pass();
    endtask

    task automatic test_random_pass();
        logic pe       = 1'b0;
        logic phase    = 1'b0;
        logic got_done = 1'b0;
        int   issues   = 0;
        int   cnt      = 0;
        cmd_t issued   = '0;
        start_pass();
        for (int cyc = 0; cyc < 30000 && !got_done; cyc++) begin
            tick();
            bus.tile_done = 1'b0;
            bus.start     = 1'b0;
            if (bus.en_tf && !pe) begin
                issued = cur_cmd();
                checks++;
                if (issues >= model_q.size() || issued !== model_q[issues]) begin
                    fails++;
                    $display("FAIL random_cmd[%0d] got %s required %s", issues, cmd_str(issued),
                             (issues < model_q.size()) ? cmd_str(model_q[issues]) : "none");
                end
                issues++;
                phase = 1'b1;
                cnt   = $urandom_range(1, 4);
                bus.tile_done = ($urandom_range(0, 3) == 0);
            end else if (phase) begin
                checks++;
                if ({bus.en_tf, bus.busy, cur_cmd()} !== {2'b11, issued}) begin
                    fails++;
                    $display("FAIL random_hold got en=%b busy=%b %s required 1 1 %s", bus.en_tf,
                             bus.busy, cmd_str(cur_cmd()), cmd_str(issued));
                end
                cnt--;
                if (cnt == 0) begin
                    bus.tile_done = 1'b1;
                    phase = 1'b0;
                end
            end
            if (bus.busy && $urandom_range(0, 7) == 0) bus.start = 1'b1;
            if (bus.done) got_done = 1'b1;
            pe = bus.en_tf;
        end
        bus.tile_done = 1'b0;
        bus.start     = 1'b0;
        checks++;
        if (!got_done || issues != 1944) begin
            fails++;
            $display("FAIL random_pass_end got done=%b issues=%0d required 1 1944", got_done, issues);
        end
        tick();
    endtask

    task automatic test_reset_midpass();
        bus.tile_done = 1'b1;
        start_pass();
        repeat (40) tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if (all_outs() !== 28'd0) begin
            fails++;
            $display("FAIL reset_async outputs=%h required 0", all_outs());
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (all_outs() !== 28'd0) begin
                fails++;
                $display("FAIL reset_release cycle %0d outputs=%h required 0", i, all_outs());
            end
        end
        bus.tile_done = 1'b0;
    endtask

    initial begin
        build_model();
        test_reset();
        test_first_tiles();
        test_full_pass();
        test_layer_boundary();
        test_abort();
        test_ignored_inputs();
        test_random_pass();
        test_reset_midpass();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Top-level sequencer for the LeNet-5 tile array. It walks C1→S2→C3→S4→C5 and, within each layer, every output map, row and column chunk. For each chunk it issues one tile command (calculation mode, layer code, coordinates) to the tile FSM and waits for the datapath's tile-complete pulse before advancing. It sits between the host start/done interface and the tile FSM inputs `i_en_tf`, `i_cal_state` and `i_layer_state`.

## Interface
- `ROWS`, 5, PE array rows; conv chunk width.
- `COLS`, 5, PE array columns (informational; must be 5).
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a full network pass; sampled only in IDLE.
- `abort` input 1: synchronous cancel; highest priority after reset.
- `tile_done` input 1: datapath finished the current tile; sampled only in WAIT.
- `en_tf` output 1: tile FSM enable; drives tile FSM `i_en_tf`.
- `cal_state` output 2: 00 IDLE, 01 FULL, 10 PART.
- `layer_state` output 3: C1=001, S2=010, C3=011, S4=100, C5=101; 000 when idle.
- `map_idx` output 7: current output map (0..119).
- `row_idx` output 5: current output row.
- `col_base` output 5: first output column of the chunk.
- `valid_cols` output 3: columns produced by this tile (1..5).
- `busy` output 1: high from the cycle after start acceptance until DONE.
- `done` output 1: one-cycle pulse at end of pass.

## Operation
- Per-layer geometry (maps, W = H, chunk width):
  - C1: 6, 28, 5.
  - S2: 6, 14, 4.
  - C3: 16, 10, 5.
  - S4: 16, 5, 4.
  - C5: 120, 1, 5.
- Chunk classification:
  - FULL when `col_base + chunk <= W`; `valid_cols = chunk`.
  - Otherwise PART; `valid_cols = W - col_base`.
- Chunks per row: C1 6 (5F+1P), S2 4 (3F+1P), C3 2 (2F), S4 2 (1F+1P), C5 1 (1P).
- Tiles per layer: C1 1008, S2 336, C3 320, S4 160, C5 120; 1944 in total.
- Loop order, innermost first: `col_base` (step = chunk), then `row_idx`, then `map_idx`, then layer.
- FSM states: IDLE, ISSUE, WAIT, ADVANCE, DONE.
  - IDLE: all outputs 0. `start` → ISSUE with layer C1 and all indices 0.
  - ISSUE (1 cycle): outputs show the tile command, `en_tf` = 1 → WAIT.
  - WAIT: hold the command stable with `en_tf` = 1. On `tile_done` → ADVANCE.
  - ADVANCE (1 cycle): `en_tf` = 0 and `cal_state` = 00, which clears the PE enables between tiles. Increment the counters. Last tile of C5 → DONE, else → ISSUE.
  - DONE (1 cycle): `done` = 1, `busy` = 0 → IDLE.
- Wrap-around:
  - `col_base` → 0 when `col_base + chunk >= W`.
  - `row_idx` → 0 at W−1.
  - `map_idx` → 0 at maps−1, and the layer advances at the same time.
- Simultaneous events:
  - `abort` beats `tile_done` and `start`.
  - `start` in any state other than IDLE is ignored.
  - `tile_done` outside WAIT is ignored.
- `abort` in any non-IDLE state → IDLE next cycle: outputs 0, no `done`.
- Reset mid-pass: all outputs 0 immediately (asynchronous); FSM goes to IDLE.

## Timing
- All outputs are registered; reset value of every output is 0.
- `start` sampled at edge N → ISSUE outputs visible after edge N+1.
- Per-tile overhead is 3 cycles minimum: ISSUE + one WAIT cycle + ADVANCE.
- The tile FSM adds 2 cycles to the PE enables. The datapath must not raise `tile_done` earlier than 2 cycles after `en_tf` rises; the scheduler does not check this.
- Command outputs are stable from ISSUE through the last WAIT cycle.

## Structure
- Shared package `accel_pkg` holds:
  - `CAL_IDLE`, `CAL_FULL`, `CAL_PART` and the layer codes.
  - The per-layer geometry constants.
  - Function `layer_last(layer)`.
- Geometry constants and layer codes are used by the tile FSM as well as this block, so both must take them from the package.
- Sub-module `layer_geom_lut`: combinational layer → {maps, W, chunk}.
- Counters and FSM live in the top.

## Test plan
- Reset: hold `rst_n` = 0 → all outputs 0. Release with no `start` → outputs stay 0.
- First tiles (C1 row 0): `start` with `tile_done` tied 1 → command sequence `col_base` 0, 5, 10, 15, 20 with `cal_state` 01, then `col_base` 25 with `cal_state` 10 and `valid_cols` 3. The next tile is `row_idx` 1, `col_base` 0.
- Full-pass cycle count: `tile_done` tied 1 → exactly 1944 ISSUE cycles. `done` pulses 5833 cycles after the `start` edge, and the last command is layer 101, map 119, PART, `valid_cols` 1.
- Layer boundary: skip to C3 map 15 row 9 `col_base` 5, then pulse `tile_done` → next command is S4 (100), map 0, row 0, `col_base` 0, FULL, `valid_cols` 4.
- Abort: assert `abort` in WAIT during S2 → next cycle `en_tf` = 0, `busy` = 0 and all outputs 0, with no `done`. A new `start` restarts at C1 map 0.
- Ignored inputs: `start` while busy → no restart. `tile_done` pulsed during ISSUE → indices unchanged.
